// File: rtl/seg_pkg.sv
// Shared types and constants for the 8-digit multiplexed 7-segment scan driver.
package seg_pkg;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] CS_OFF  = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a}; entry 0 sits in the least-significant byte.
    localparam logic [15:0][7:0] SEG_LUT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] seg_encode(input logic [3:0] nibble, input logic dp);
        logic [7:0] pat;
        pat = SEG_LUT[nibble];
        return {pat[7] & ~dp, pat[6:0]};
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble + decimal point to active-low segment pattern.
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] o_seg
);

    // Table lookup with the dp bit folded in.
    always_comb begin
        o_seg = SEG_OFF;
        o_seg = seg_encode(nibble, dp);
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit 7-segment driver: slot counter, enabled-digit scan,
// blanking gap, double-buffered display data and registered active-low outputs.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int F_CLK     = 50000000,
    parameter int F_SCAN    = 1000,
    parameter int BLANK_CYC = 500
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_data,
    input  logic [7:0]  i_dp,
    input  logic [7:0]  i_en_mask,
    input  logic        i_load,
    output logic [7:0]  o_cs,
    output logic [7:0]  o_seg,
    output logic        o_frame
);

    localparam int DIV = F_CLK / F_SCAN;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    logic [CW-1:0] cnt_r;
    logic [2:0]    ptr_r;
    state_t        state_r;
    state_t        state_nxt_s;
    logic [31:0]   act_data_r;
    logic [7:0]    act_dp_r;
    logic [31:0]   pend_data_r;
    logic [7:0]    pend_dp_r;
    logic          pend_valid_r;

    logic          slot_end_s;
    logic [3:0]    ptr_plus1_s;
    logic [15:0]   dbl_mask_s;
    logic [7:0]    rot_mask_s;
    logic          hit_s;
    logic [2:0]    step_s;
    logic [3:0]    sum_s;
    logic          frame_s;
    logic [3:0]    nib_s;
    logic          dp_s;
    logic [7:0]    dec_seg_s;
    logic [7:0]    cs_nxt_s;
    logic [7:0]    seg_nxt_s;

    assign slot_end_s  = (cnt_r == CNT_LAST);
    assign ptr_plus1_s = {1'b0, ptr_r} + 4'd1;
    assign dbl_mask_s  = {i_en_mask, i_en_mask};
    // Bit j of the rotated mask is digit (ptr+1+j) mod 8, so the lowest set bit is the next digit.
    assign rot_mask_s  = 8'(dbl_mask_s >> ptr_plus1_s);

    // Priority scan: lowest set bit of the rotated mask wins.
    always_comb begin
        hit_s  = 1'b0;
        step_s = 3'd0;
        for (int j = 7; j >= 0; j--) begin
            if (rot_mask_s[j]) begin
                hit_s  = 1'b1;
                step_s = 3'(j);
            end else begin
                step_s = step_s;
            end
        end
    end

    // A carry out of the 3-bit pointer means the search wrapped past digit 7.
    assign sum_s   = {1'b0, ptr_r} + {1'b0, step_s} + 4'd1;
    assign frame_s = slot_end_s & (~hit_s | sum_s[3]);

    assign nib_s = act_data_r[{ptr_r, 2'b00} +: 4];
    assign dp_s  = act_dp_r[ptr_r];

    hex7seg u_hex7seg (
        .nibble (nib_s),
        .dp     (dp_s),
        .o_seg  (dec_seg_s)
    );

    // Slot counter and digit pointer; pointer holds when nothing is enabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r <= '0;
            ptr_r <= 3'd0;
        end else if (slot_end_s) begin
            cnt_r <= '0;
            ptr_r <= hit_s ? sum_s[2:0] : ptr_r;
        end else begin
            cnt_r <= cnt_r + 1'b1;
            ptr_r <= ptr_r;
        end
    end

    // Double buffer: a load in the copy cycle lands in pending and stays valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            act_data_r   <= 32'h0000_0000;
            act_dp_r     <= 8'h00;
            pend_data_r  <= 32'h0000_0000;
            pend_dp_r    <= 8'h00;
            pend_valid_r <= 1'b0;
        end else begin
            if (frame_s && pend_valid_r) begin
                act_data_r <= pend_data_r;
                act_dp_r   <= pend_dp_r;
            end
            if (i_load) begin
                pend_data_r  <= i_data;
                pend_dp_r    <= i_dp;
                pend_valid_r <= 1'b1;
            end else if (frame_s) begin
                pend_valid_r <= 1'b0;
            end
        end
    end

    // Phase state register; tracks whether cnt_r is in the blank window.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= BLANK;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next phase plus the select/segment values to register this cycle.
    always_comb begin
        state_nxt_s = state_r;
        cs_nxt_s    = CS_OFF;
        seg_nxt_s   = SEG_OFF;
        case (state_r)
            BLANK: begin
                if (cnt_r == BLANK_LAST) begin
                    state_nxt_s = SHOW;
                end else begin
                    state_nxt_s = BLANK;
                end
            end
            SHOW: begin
                if (slot_end_s) begin
                    state_nxt_s = BLANK;
                end else begin
                    state_nxt_s = SHOW;
                end
                if (i_en_mask[ptr_r]) begin
                    cs_nxt_s  = ~(8'h01 << ptr_r);
                    seg_nxt_s = dec_seg_s;
                end else begin
                    cs_nxt_s  = CS_OFF;
                    seg_nxt_s = SEG_OFF;
                end
            end
            default: begin
                state_nxt_s = BLANK;
            end
        endcase
    end

    // Registered outputs, one cycle behind cnt_r/ptr_r.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cs    <= CS_OFF;
            o_seg   <= SEG_OFF;
            o_frame <= 1'b0;
        end else begin
            o_cs    <= cs_nxt_s;
            o_seg   <= seg_nxt_s;
            o_frame <= frame_s;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed scenarios plus random traffic against a digit-level model.
module tb_seg_scan_driver;

    localparam int DIV = 10;
    localparam int BLK = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  mask;
    logic        load;
    logic [7:0]  cs;
    logic [7:0]  seg;
    logic        frame;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .F_CLK     (100),
        .F_SCAN    (10),
        .BLANK_CYC (BLK)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_data    (data),
        .i_dp      (dp),
        .i_en_mask (mask),
        .i_load    (load),
        .o_cs      (cs),
        .o_seg     (seg),
        .o_frame   (frame)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc = 0;
    int last_frame = -1;
    int frame_gap  = 0;

    // Model: position in slot, displayed digit, active/pending digit arrays.
    int         m_pos;
    int         m_dig;
    logic [3:0] m_act  [8];
    logic [3:0] m_pend [8];
    logic [7:0] m_act_dp;
    logic [7:0] m_pend_dp;
    bit         m_pv;
    logic [7:0] e_cs;
    logic [7:0] e_seg;
    logic       e_frame;

    function automatic logic [7:0] ref_seg(input logic [3:0] n, input logic d);
        logic [7:0] p;
        case (n)
            4'h0: p = 8'hC0;  4'h1: p = 8'hF9;  4'h2: p = 8'hA4;  4'h3: p = 8'hB0;
            4'h4: p = 8'h99;  4'h5: p = 8'h92;  4'h6: p = 8'h82;  4'h7: p = 8'hF8;
            4'h8: p = 8'h80;  4'h9: p = 8'h90;  4'hA: p = 8'h88;  4'hB: p = 8'h83;
            4'hC: p = 8'hC6;  4'hD: p = 8'hA1;  4'hE: p = 8'h86;  default: p = 8'h8E;
        endcase
        return d ? (p & 8'h7F) : p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pos = 0;
        m_dig = 0;
        m_pv  = 1'b0;
        m_act_dp  = 8'h00;
        m_pend_dp = 8'h00;
        for (int k = 0; k < 8; k++) begin
            m_act[k]  = 4'h0;
            m_pend[k] = 4'h0;
        end
    endtask

    task automatic model_eval();
        int  nd;
        bit  found;
        bit  wrapped;
        bit  show;
        show    = (m_pos >= BLK) && mask[m_dig];
        e_cs    = show ? ~(8'h01 << m_dig) : 8'hFF;
        e_seg   = show ? ref_seg(m_act[m_dig], m_act_dp[m_dig]) : 8'hFF;
        e_frame = 1'b0;
        if (m_pos == DIV - 1) begin
            found = 1'b0;
            wrapped = 1'b0;
            nd = m_dig;
            for (int i = 1; i <= 8; i++) begin
                if (!found && mask[(m_dig + i) % 8]) begin
                    found   = 1'b1;
                    nd      = (m_dig + i) % 8;
                    wrapped = (m_dig + i) >= 8;
                end
            end
            e_frame = !found || wrapped;
            if (e_frame && m_pv) begin
                for (int k = 0; k < 8; k++) m_act[k] = m_pend[k];
                m_act_dp = m_pend_dp;
                m_pv = 1'b0;
            end
            m_dig = nd;
            m_pos = 0;
        end else begin
            m_pos++;
        end
        if (load) begin
            for (int k = 0; k < 8; k++) m_pend[k] = data[4*k +: 4];
            m_pend_dp = dp;
            m_pv = 1'b1;
        end
    endtask

    task automatic cycle(input bit ld);
        load = ld;
        model_eval();
        @(posedge clk);
        #1;
        cyc++;
        chk("o_cs", 32'(cs), 32'(e_cs));
        chk("o_seg", 32'(seg), 32'(e_seg));
        chk("o_frame", 32'(frame), 32'(e_frame));
        if (frame) begin
            if (last_frame >= 0) frame_gap = cyc - last_frame;
            last_frame = cyc;
        end
        load = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) cycle(1'b0);
    endtask

    task automatic wait_frame();
        int k;
        k = 0;
        do begin
            cycle(1'b0);
            k++;
        end while (!frame && k < 100);
        chk("frame_seen", 32'(frame), 32'd1);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        load  = 1'b0;
        data  = 32'h0;
        dp    = 8'h00;
        mask  = 8'hFF;
        #12;
        chk("rst_cs", 32'(cs), 32'hFF);
        chk("rst_seg", 32'(seg), 32'hFF);
        chk("rst_frame", 32'(frame), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_reset();

        // Initial scan with 76543210.
        data = 32'h7654_3210;
        cycle(1'b1);
        chk("c1_cs", 32'(cs), 32'hFF);
        run(1);
        chk("c2_cs", 32'(cs), 32'hFF);
        run(1);
        chk("c3_cs", 32'(cs), 32'hFE);
        chk("c3_seg", 32'(seg), 32'hC0);
        wait_frame();
        run(13);
        chk("d1_cs", 32'(cs), 32'hFD);
        chk("d1_seg", 32'(seg), 32'hF9);

        // Two enabled digits: frame every 20 cycles.
        mask = 8'h81;
        run(70);
        chk("gap_81", frame_gap, 32'd20);

        // Mid-frame load of 8s with all decimal points.
        mask = 8'hFF;
        wait_frame();
        run(25);
        data = 32'h8888_8888;
        dp   = 8'hFF;
        cycle(1'b1);
        data = 32'hDEAD_BEEF;
        dp   = 8'h00;
        wait_frame();
        run(3);
        chk("eights_cs", 32'(cs), 32'hFE);
        chk("eights_seg", 32'(seg), 32'h00);

        // Two loads in one frame: last wins.
        wait_frame();
        run(5);
        data = 32'h1111_1111;
        cycle(1'b1);
        run(20);
        data = 32'h2222_2222;
        cycle(1'b1);
        data = 32'h0;
        wait_frame();
        run(3);
        chk("twos_seg", 32'(seg), 32'hA4);

        // Nothing enabled: outputs off, frame every slot.
        mask = 8'h00;
        run(35);
        chk("gap_00", frame_gap, 32'd10);
        chk("off_cs", 32'(cs), 32'hFF);
        mask = 8'hFF;
        run(30);

        // Random masks, data and loads.
        repeat (12) begin
            mask = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            repeat (25) begin
                data = $urandom;
                dp   = 8'($urandom);
                cycle($urandom_range(0, 7) == 0);
            end
        end

        // Asynchronous reset while digit 3 is shown.
        mask = 8'hFF;
        k = 0;
        do begin
            cycle(1'b0);
            k++;
        end while (cs !== 8'hF7 && k < 100);
        chk("dig3_seen", 32'(cs), 32'hF7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cs", 32'(cs), 32'hFF);
        chk("arst_seg", 32'(seg), 32'hFF);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_reset();
        cyc = 0;
        last_frame = -1;
        run(3);
        chk("restart_cs", 32'(cs), 32'hFE);
        chk("restart_seg", 32'(seg), 32'hC0);
        run(12);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
